// File: rtl/cla_stage_pkg.sv
// rtl/cla_stage_pkg.sv - shared state encoding, defaults and overflow rule for the CLA operand stage
package cla_stage_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } stage_state_e;

    localparam int DEFAULT_WIDTH         = 32;
    localparam int DEFAULT_SETTLE_CYCLES = 4;

    // Two's-complement overflow: operands agree in sign, result sign differs.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic sum_msb);
        return (a_msb == b_msb) && (sum_msb != a_msb);
    endfunction

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable down-counter that flags when the settle window has elapsed
module settle_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cla_operand_stage.sv
// rtl/cla_operand_stage.sv - registers operands onto the CLA, waits out the ripple, captures the result
module cla_operand_stage
    import cla_stage_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    // Counter is preloaded with SETTLE_CYCLES-1 so capture lands SETTLE_CYCLES edges after accept.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

    stage_state_e state;
    stage_state_e state_next;
    logic         accept;
    logic         capture;
    logic         timer_zero;

    settle_timer #(
        .CNT_W(CNT_W)
    ) u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .en      (state == SETTLE),
        .load_val(LOAD_VAL),
        .zero    (timer_zero)
    );

    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            HOLD:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept  = in_valid & in_ready;
    assign capture = (state == SETTLE) & timer_zero;
    assign busy    = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = SETTLE;
            end
            SETTLE: begin
                if (timer_zero) state_next = HOLD;
            end
            HOLD: begin
                if (out_ready) state_next = in_valid ? SETTLE : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
        end else if (accept) begin
            add_a   <= in_a;
            add_b   <= in_b;
            add_cin <= in_cin;
        end
    end

    // Result fields persist after retirement; only out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_sum   <= add_sum;
            out_cout  <= add_cout;
            out_ovf   <= signed_ovf(add_a[WIDTH-1], add_b[WIDTH-1], add_sum[WIDTH-1]);
        end else if ((state == HOLD) && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
